operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Read/operand-fetch stage directly downstream of the 8x16 register array (R0 hard-wired 0, R1..R7 stored).
//  - Accepts a read request (two source selects plus a destination tag) over a valid/ready handshake.
//  - Returns both 16-bit operands through a one-entry output pipeline register.
//  - Snoops the array's write port and clear so captured or held operands never go stale.
// PARAMETERS
//  WIDTH  16  data width of each register/operand
//  NREG   8   architectural registers incl. R0 (R0 not stored, reads 0)
//  SELW   3   select width, = clog2(NREG)
// PORTS
//  CLK       in   1                clock, all state updates on rising edge
//  RST       in   1                synchronous, active-high reset
//  REGS_FLAT in   WIDTH*(NREG-1)   array contents; bits [WIDTH*(i-1) +: WIDTH] = R[i], i=1..7
//  WR_SEL    in   SELW             register being written by the array at this edge (0 = no write)
//  WR_DATA   in   WIDTH            data written by the array at this edge
//  RF_CLR    in   1                array clears R1..R7 at this edge
//  IN_VALID  in   1                read request valid
//  IN_READY  out  1                stage can accept a request this cycle
//  IN_SA     in   SELW             source A select
//  IN_SB     in   SELW             source B select
//  IN_DSEL   in   SELW             destination tag, passed through untouched
//  OUT_VALID out  1                OUT_A/OUT_B/OUT_DSEL valid
//  OUT_READY in   1                consumer accepts output this cycle
//  OUT_A     out  WIDTH            operand A
//  OUT_B     out  WIDTH            operand B
//  OUT_DSEL  out  SELW             destination tag of the held request
// BEHAVIOUR
//  Reset (RST=1 at edge): OUT_VALID=0, OUT_A=OUT_B=0, OUT_DSEL=0, held SA/SB=0. IN_READY=0 while RST=1.
//  IN_READY = !RST && (!OUT_VALID || OUT_READY). This is combinational; it is the only comb path in->out.
//  Accept: IN_VALID && IN_READY at edge.
//   - Captures the operands, IN_DSEL, IN_SA and IN_SB.
//   - OUT_VALID=1 next cycle (latency 1).
//   - Back-to-back accepts give full throughput.
//  Operand value per source s, in priority order:
//   (1) s==0 -> 0
//   (2) RF_CLR -> 0
//   (3) WR_SEL==s (s!=0) -> WR_DATA (same-edge write bypass)
//   (4) otherwise REGS_FLAT slot s
//  WR_SEL==0 is never a write. SA==SB is legal; both operands get the same value.
//  Retire: OUT_VALID && OUT_READY && !accept -> OUT_VALID=0. Data regs hold their last value.
//  Stall: OUT_VALID && !OUT_READY. The entry holds and IN_READY=0.
//   Held operands are refreshed each edge using the same rules with held SA/SB.
//   Priority: RF_CLR zeroes both; then WR_SEL match overwrites the matching operand(s).
//   OUT_DSEL never changes while stalled.
//  Idle (OUT_VALID=0): no refresh is needed; values are don't-care but must be deterministic (hold).
//  RST mid-stall or mid-accept: reset wins and the pending request is dropped. Upstream must re-present it.
//  Out-of-range selects cannot occur with NREG=2**SELW. Otherwise, selects >= NREG read 0.
// TESTING
//  1 Reset: RST=1 for 2 edges with IN_VALID=1 -> IN_READY=0; after reset OUT_VALID=0, OUT_A=OUT_B=0.
//  2 Plain read: R3=16'h1234, R5=16'hBEEF; IN_SA=3, IN_SB=5, IN_DSEL=2, OUT_READY=1
//    -> next cycle OUT_VALID=1, OUT_A=1234, OUT_B=BEEF, OUT_DSEL=2.
//  3 Bypass: R4=16'h0001; same cycle WR_SEL=4, WR_DATA=16'hA5A5; IN_SA=4, IN_SB=0
//    -> OUT_A=A5A5, OUT_B=0000; with WR_SEL=0 instead -> OUT_A=0001.
//  4 Stall refresh: hold OUT_READY=0 with SA=SB=6 (R6=16'h0010); write R6=16'h0F0F
//    -> OUT_A=OUT_B=0F0F next cycle, IN_READY=0; then RF_CLR=1 -> both 0000; OUT_DSEL unchanged.
//  5 Throughput: 8 back-to-back requests, OUT_READY=1 -> 8 outputs on 8 consecutive cycles in order.
//    Toggle OUT_READY 1/0 -> no loss or duplication; scoreboard vs reference model.
//  6 Reset mid-stall: OUT_VALID=1, OUT_READY=0, assert RST one edge
//    -> OUT_VALID=0, OUT_A=OUT_B=0; the dropped request is never emitted.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand-fetch stage behind the 8x16 register array: captures both source operands
// into a one-entry output register and keeps them coherent with array writes and clears.
module operand_fetch #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int SELW  = 3
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [WIDTH*(NREG-1)-1:0]   REGS_FLAT,
    input  logic [SELW-1:0]             WR_SEL,
    input  logic [WIDTH-1:0]            WR_DATA,
    input  logic                        RF_CLR,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic [SELW-1:0]             IN_SA,
    input  logic [SELW-1:0]             IN_SB,
    input  logic [SELW-1:0]             IN_DSEL,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [WIDTH-1:0]            OUT_A,
    output logic [WIDTH-1:0]            OUT_B,
    output logic [SELW-1:0]             OUT_DSEL
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [SELW-1:0]  out_dsel_q, out_dsel_d;
    logic [SELW-1:0]  sa_q, sa_d;
    logic [SELW-1:0]  sb_q, sb_d;
    logic             in_ready;
    logic             accept;

    function automatic logic [WIDTH-1:0] slot_value(
        input logic [SELW-1:0]           sel,
        input logic [WIDTH*(NREG-1)-1:0] regs
    );
        logic [WIDTH-1:0] val;
        val = '0;
        for (int i = 1; i < NREG; i++) begin
            if (sel == SELW'(i)) val = regs[WIDTH*(i-1) +: WIDTH];
        end
        return val;
    endfunction

    // Priority: R0 / out-of-range, then clear, then same-edge write, then base value.
    function automatic logic [WIDTH-1:0] resolve(
        input logic [SELW-1:0]  sel,
        input logic [WIDTH-1:0] base,
        input logic             clr,
        input logic [SELW-1:0]  wr_sel,
        input logic [WIDTH-1:0] wr_data
    );
        logic [WIDTH-1:0] val;
        if (sel == '0 || int'(sel) >= NREG) val = '0;
        else if (clr)                       val = '0;
        else if (wr_sel == sel)             val = wr_data;
        else                                val = base;
        return val;
    endfunction

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no path can infer a latch.
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_dsel_d  = out_dsel_q;
        sa_d        = sa_q;
        sb_d        = sb_q;

        in_ready = !RST && (!out_valid_q || OUT_READY);
        accept   = IN_VALID && in_ready;

        if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = resolve(IN_SA, slot_value(IN_SA, REGS_FLAT), RF_CLR, WR_SEL, WR_DATA);
            out_b_d     = resolve(IN_SB, slot_value(IN_SB, REGS_FLAT), RF_CLR, WR_SEL, WR_DATA);
            out_dsel_d  = IN_DSEL;
            sa_d        = IN_SA;
            sb_d        = IN_SB;
        end else if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            // Stalled entry snoops the array so it never goes stale while held.
            out_a_d = resolve(sa_q, out_a_q, RF_CLR, WR_SEL, WR_DATA);
            out_b_d = resolve(sb_q, out_b_q, RF_CLR, WR_SEL, WR_DATA);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins over accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_dsel_q  <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_dsel_q  <= out_dsel_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid_q;
    assign OUT_A     = out_a_q;
    assign OUT_B     = out_b_q;
    assign OUT_DSEL  = out_dsel_q;

endmodule
